// File: rtl/ones_run_gen_if.sv
// Command and output-stream bundle for ones_run_gen.
// The master side issues commands and consumes words; the slave side is the generator.
interface ones_run_gen_if #(
    parameter int unsigned WORD_SIZE = 256
);
    localparam int unsigned LW = $clog2(WORD_SIZE) + 1;
    localparam int unsigned PW = $clog2(WORD_SIZE);

    logic                 start;
    logic                 mode;
    logic [PW-1:0]        cmd_pos;
    logic [LW-1:0]        cmd_len;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_word;
    logic [LW-1:0]        out_len;
    logic [PW-1:0]        out_pos;
    logic                 out_last;
    logic                 done;

    modport master (
        output start, mode, cmd_pos, cmd_len, out_ready,
        input  busy, out_valid, out_word, out_len, out_pos, out_last, done
    );

    modport slave (
        input  start, mode, cmd_pos, cmd_len, out_ready,
        output busy, out_valid, out_word, out_len, out_pos, out_last, done
    );
endinterface

// File: rtl/ones_run_gen.sv
// Generates words containing a single contiguous run of ones: one word per single
// command, or every (len, pos) placement up to a maximum length in sweep mode.
module ones_run_gen #(
    parameter int unsigned WORD_SIZE = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    ones_run_gen_if.slave bus
);
    localparam int unsigned LW = $clog2(WORD_SIZE) + 1;
    localparam int unsigned PW = $clog2(WORD_SIZE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [LW-1:0] WS_L = LW'(WORD_SIZE);

    logic [1:0]           state,     state_nxt;
    logic                 mode_q,    mode_nxt;
    logic [LW-1:0]        max_len_q, max_len_nxt;
    logic                 busy_q,    busy_nxt;
    logic                 valid_q,   valid_nxt;
    logic [WORD_SIZE-1:0] word_q,    word_nxt;
    logic [LW-1:0]        len_q,     len_nxt;
    logic [PW-1:0]        pos_q,     pos_nxt;
    logic                 last_q,    last_nxt;
    logic                 done_q,    done_nxt;

    logic [LW-1:0] cmd_len_clamp;
    logic [LW-1:0] single_len;
    logic          sweep_wrap;
    logic [LW-1:0] adv_len;
    logic [PW-1:0] adv_pos;
    logic          adv_last;
    logic          handshake;

    // Run of len ones starting at bit pos; the extra top bit makes len == WORD_SIZE work.
    function automatic logic [WORD_SIZE-1:0] run_mask(input logic [LW-1:0] len,
                                                      input logic [PW-1:0] pos);
        logic [WORD_SIZE:0] one_hot;
        one_hot = (WORD_SIZE+1)'(1) << len;
        return WORD_SIZE'(one_hot - (WORD_SIZE+1)'(1)) << pos;
    endfunction

    // LW bits hold pos+len up to 2*WORD_SIZE-1, so these sums cannot wrap.
    assign cmd_len_clamp = (bus.cmd_len > WS_L) ? WS_L : bus.cmd_len;
    assign single_len    = ((LW'(bus.cmd_pos) + cmd_len_clamp) > WS_L)
                         ? (WS_L - LW'(bus.cmd_pos)) : cmd_len_clamp;

    // Sweep stepping: pos climbs to WORD_SIZE-len, then len grows and pos restarts at 0.
    assign sweep_wrap = (LW'(pos_q) == (WS_L - len_q));
    assign adv_len    = sweep_wrap ? (len_q + LW'(1)) : len_q;
    assign adv_pos    = sweep_wrap ? '0 : (pos_q + PW'(1));
    assign adv_last   = (adv_len == max_len_q) && ((LW'(adv_pos) + adv_len) == WS_L);
    assign handshake  = valid_q && bus.out_ready;

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        max_len_nxt = max_len_q;
        valid_nxt   = valid_q;
        len_nxt     = len_q;
        pos_nxt     = pos_q;
        last_nxt    = last_q;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt   = S_EMIT;
                    mode_nxt    = bus.mode;
                    max_len_nxt = cmd_len_clamp;
                    valid_nxt   = 1'b1;
                    if (!bus.mode) begin
                        len_nxt  = single_len;
                        pos_nxt  = bus.cmd_pos;
                        last_nxt = 1'b1;
                    end else if (cmd_len_clamp == '0) begin
                        len_nxt  = '0;
                        pos_nxt  = '0;
                        last_nxt = 1'b1;
                    end else begin
                        // len 1 at pos 0 is never the final placement since WORD_SIZE >= 8
                        len_nxt  = LW'(1);
                        pos_nxt  = '0;
                        last_nxt = 1'b0;
                    end
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    if (last_q || !mode_q) begin
                        state_nxt = S_DONE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        len_nxt  = adv_len;
                        pos_nxt  = adv_pos;
                        last_nxt = adv_last;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
        word_nxt = run_mask(len_nxt, pos_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            max_len_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            len_q     <= '0;
            pos_q     <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            max_len_q <= max_len_nxt;
            busy_q    <= busy_nxt;
            valid_q   <= valid_nxt;
            word_q    <= word_nxt;
            len_q     <= len_nxt;
            pos_q     <= pos_nxt;
            last_q    <= last_nxt;
            done_q    <= done_nxt;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_word  = word_q;
    assign bus.out_len   = len_q;
    assign bus.out_pos   = pos_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ones_run_gen.sv
// Self-checking bench for ones_run_gen at WORD_SIZE=16: single-word table, sweeps
// with back-pressure, start-while-busy, and mid-sweep reset.
module tb_ones_run_gen;
    localparam int unsigned WS = 16;
    localparam int unsigned LW = 5;
    localparam int unsigned PW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ones_run_gen_if #(.WORD_SIZE(WS)) bus();
    ones_run_gen #(.WORD_SIZE(WS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [WS-1:0] word;
        logic [LW-1:0] len;
        logic [PW-1:0] pos;
        logic          last;
    } exp_t;

    typedef struct {
        int   pos;
        int   len;
        exp_t exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [WS-1:0] model_word(input int pos, input int len);
        logic [WS-1:0] w;
        w = '0;
        for (int i = 0; i < int'(WS); i++)
            if (i >= pos && i < pos + len) w[i] = 1'b1;
        return w;
    endfunction

    function automatic int longest_run(input logic [WS-1:0] w);
        int best, cur;
        best = 0;
        cur  = 0;
        for (int i = 0; i < int'(WS); i++) begin
            cur  = w[i] ? cur + 1 : 0;
            best = (cur > best) ? cur : best;
        end
        return best;
    endfunction

    task automatic push_sweep(input int maxl, output int count);
        int   m;
        exp_t e;
        m = (maxl > int'(WS)) ? int'(WS) : maxl;
        count = 0;
        if (m == 0) begin
            e = '{word: '0, len: '0, pos: '0, last: 1'b1};
            sb.push_back(e);
            count = 1;
        end else begin
            for (int l = 1; l <= m; l++)
                for (int p = 0; p <= int'(WS) - l; p++) begin
                    e.word = model_word(p, l);
                    e.len  = LW'(l);
                    e.pos  = PW'(p);
                    e.last = (l == m) && (p == int'(WS) - m);
                    sb.push_back(e);
                    count++;
                end
        end
    endtask

    // Issues one command and consumes its words, scoring each against the queue.
    task automatic run_cmd(input logic md, input int pos, input int len, input bit rnd_ready,
                           input bit poke, input int exp_words, input string tag);
        int            words;
        int            cyc;
        bit            fin;
        bit            stalled;
        logic [31:0]   prev;
        exp_t          e;
        words   = 0;
        cyc     = 0;
        fin     = 1'b0;
        stalled = 1'b0;
        prev    = '0;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.mode      = md;
        bus.cmd_pos   = PW'(pos);
        bus.cmd_len   = LW'(len);
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.cmd_pos = '0;
        bus.cmd_len = '0;
        @(negedge clk);
        chk({tag, " latency valid"}, 32'(bus.out_valid), 32'd1);
        while (!fin && cyc < 1000) begin
            chk({tag, " valid held"}, 32'(bus.out_valid), 32'd1);
            if (stalled)
                chk({tag, " stall hold"},
                    32'({bus.out_word, bus.out_len, bus.out_pos, bus.out_last}), prev);
            if (bus.out_ready) begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s extra word: got %0h want none", tag, bus.out_word);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " word"}, 32'(bus.out_word), 32'(e.word));
                    chk({tag, " len"},  32'(bus.out_len),  32'(e.len));
                    chk({tag, " pos"},  32'(bus.out_pos),  32'(e.pos));
                    chk({tag, " last"}, 32'(bus.out_last), 32'(e.last));
                end
                chk({tag, " ones run"}, 32'(longest_run(bus.out_word)), 32'(bus.out_len));
                words++;
                if (bus.out_last) fin = 1'b1;
            end else begin
                stalled = 1'b1;
                prev    = 32'({bus.out_word, bus.out_len, bus.out_pos, bus.out_last});
            end
            @(posedge clk); #1;
            if (!fin) begin
                bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke && words < 8) begin
                    bus.start   = 1'($urandom_range(0, 1));
                    bus.mode    = 1'b0;
                    bus.cmd_pos = PW'(7);
                    bus.cmd_len = LW'(1);
                end
                @(negedge clk);
            end
            cyc++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d words want %0d", tag, words, exp_words);
        end
        @(negedge clk);
        chk({tag, " valid after last"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " done pulse"},       32'(bus.done),      32'd1);
        chk({tag, " busy in done"},     32'(bus.busy),      32'd1);
        @(negedge clk);
        chk({tag, " done cleared"}, 32'(bus.done), 32'd0);
        chk({tag, " busy cleared"}, 32'(bus.busy), 32'd0);
        chk({tag, " word count"},   32'(words), 32'(exp_words));
        chk({tag, " queue empty"},  32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{pos: 3,  len: 4,  exp: '{word: 16'h0078, len: 5'd4,  pos: 4'd3,  last: 1'b1}};
        vecs[1] = '{pos: 14, len: 5,  exp: '{word: 16'hC000, len: 5'd2,  pos: 4'd14, last: 1'b1}};
        vecs[2] = '{pos: 0,  len: 16, exp: '{word: 16'hFFFF, len: 5'd16, pos: 4'd0,  last: 1'b1}};
        vecs[3] = '{pos: 0,  len: 0,  exp: '{word: 16'h0000, len: 5'd0,  pos: 4'd0,  last: 1'b1}};
        vecs[4] = '{pos: 5,  len: 31, exp: '{word: 16'hFFE0, len: 5'd11, pos: 4'd5,  last: 1'b1}};
        vecs[5] = '{pos: 15, len: 1,  exp: '{word: 16'h8000, len: 5'd1,  pos: 4'd15, last: 1'b1}};

        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.cmd_pos   = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs",
            32'({bus.busy, bus.out_valid, bus.out_len, bus.out_pos, bus.out_last, bus.done}), 32'd0);
        chk("reset word", 32'(bus.out_word), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            sb.push_back(vecs[i].exp);
            run_cmd(1'b0, vecs[i].pos, vecs[i].len, 1'b0, 1'b0, 1, "single");
        end

        push_sweep(2, n);
        run_cmd(1'b1, 0, 2, 1'b0, 1'b0, 31, "sweep2");
        push_sweep(2, n);
        run_cmd(1'b1, 0, 2, 1'b1, 1'b1, 31, "sweep2 stall");
        push_sweep(0, n);
        run_cmd(1'b1, 9, 0, 1'b0, 1'b0, 1, "sweep0");
        push_sweep(20, n);
        run_cmd(1'b1, 0, 20, 1'b0, 1'b0, n, "sweep full");

        // Reset in the middle of a sweep, then a fresh command.
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.mode    = 1'b1;
        bus.cmd_len = LW'(2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midsweep valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset async outputs",
            32'({bus.busy, bus.out_valid, bus.out_len, bus.out_pos, bus.out_last, bus.done}), 32'd0);
        chk("reset async word", 32'(bus.out_word), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post reset idle", 32'({bus.busy, bus.out_valid}), 32'd0);
        end
        sb.push_back('{word: 16'hFFFF, len: 5'd16, pos: 4'd0, last: 1'b1});
        run_cmd(1'b0, 0, 16, 1'b0, 1'b0, 1, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
